// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC tracking and j/branch/jr redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_ex,
    input  logic               zero_ex,
    input  logic [31:0]        seOut,
    input  logic               jr_ex,
    input  logic [31:0]        reg_Da,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        Instructions,
    output logic [31:0]        pc_out,
    output logic               fetch_valid,
    output logic               flush_id
);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc_ex;
    logic [31:0] r_instr_id;
    logic        r_valid_id;
    logic        r_valid_ex;

    logic        w_running;
    logic        w_ex_taken;
    logic [31:0] w_ex_target;
    logic        w_id_jump;
    logic [31:0] w_pc_id_p4;
    logic [31:0] w_j_target;
    logic        w_unused;

    // Offset bits above 30 and the byte bits of the jr register cannot affect a word target.
    assign w_unused = ^{seOut[31:30], reg_Da[1:0], w_pc_id_p4[27:0]};

    assign w_running  = (r_state == S_RUN) && !rst;
    assign w_ex_taken = r_valid_ex && ((branch_ex && zero_ex) || jr_ex);
    assign w_pc_id_p4 = r_pc_id + 32'd4;
    assign w_j_target = {w_pc_id_p4[31:28], r_instr_id[25:0], 2'b00};
    assign w_id_jump  = r_valid_id && (r_instr_id[31:26] == 6'b000010) && !w_ex_taken;

    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign pc_out    = r_pc;

    // Redirect target from EX: jr takes precedence over a simultaneous branch.
    always_comb begin
        w_ex_target = r_pc_ex + 32'd4 + {seOut[29:0], 2'b00};
        if (jr_ex) begin
            w_ex_target = {reg_Da[31:2], 2'b00};
        end
    end

    // Fetch presentation: squash the word whenever a redirect is resolving this cycle.
    always_comb begin
        Instructions = 32'h0;
        fetch_valid  = 1'b0;
        flush_id     = 1'b0;
        if (w_running) begin
            flush_id = w_ex_taken;
            if (!w_ex_taken && !w_id_jump) begin
                Instructions = imem_data;
                fetch_valid  = 1'b1;
            end
        end
    end

    // PC, pipeline PC history and boot sequencing; EX redirect overrides stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_pc_id    <= 32'h0;
            r_pc_ex    <= 32'h0;
            r_instr_id <= 32'h0;
            r_valid_id <= 1'b0;
            r_valid_ex <= 1'b0;
        end else if (r_state == S_BOOT) begin
            r_state <= S_RUN;
        end else if (w_ex_taken || !stall) begin
            r_pc_id    <= r_pc;
            r_instr_id <= Instructions;
            r_valid_id <= fetch_valid;
            r_pc_ex    <= r_pc_id;
            r_valid_ex <= r_valid_id && !flush_id;
            if (w_ex_taken) begin
                r_pc <= w_ex_target;
            end else if (w_id_jump) begin
                r_pc <= w_j_target;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_ex;
    logic        zero_ex;
    logic [31:0] seOut;
    logic        jr_ex;
    logic [31:0] reg_Da;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] Instructions;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush_id;

    logic [31:0] imem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_ex    (branch_ex),
        .zero_ex      (zero_ex),
        .seOut        (seOut),
        .jr_ex        (jr_ex),
        .reg_Da       (reg_Da),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .Instructions (Instructions),
        .pc_out       (pc_out),
        .fetch_valid  (fetch_valid),
        .flush_id     (flush_id)
    );

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] e_instr, input logic e_fv,
                       input logic [31:0] e_pc, input logic e_flush);
        #1;
        chk({tag, ".instr"}, Instructions, e_instr);
        chk({tag, ".fv"}, {31'h0, fetch_valid}, {31'h0, e_fv});
        chk({tag, ".pc"}, pc_out, e_pc);
        chk({tag, ".flush"}, {31'h0, flush_id}, {31'h0, e_flush});
        @(negedge clk);
    endtask

    task automatic clr;
        stall = 0; branch_ex = 0; zero_ex = 0; seOut = 0; jr_ex = 0; reg_Da = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = i + 1;
        imem[11]  = 32'h0800_0040;
        imem[65]  = 32'h0800_0300;
        imem[129] = 32'h0800_0010;
        clr();
        rst = 1;
        @(negedge clk);
        cyc("rst0", 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("rst1", 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 0;
        cyc("boot", 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("f0", 32'd1, 1'b1, 32'h0, 1'b0);
        cyc("f4", 32'd2, 1'b1, 32'h4, 1'b0);
        stall = 1;
        cyc("st0", 32'd3, 1'b1, 32'h8, 1'b0);
        cyc("st1", 32'd3, 1'b1, 32'h8, 1'b0);
        cyc("st2", 32'd3, 1'b1, 32'h8, 1'b0);
        stall = 0;
        cyc("st_rel", 32'd3, 1'b1, 32'h8, 1'b0);
        // taken branch from pc_ex=4, offset 5 words -> 28
        branch_ex = 1; zero_ex = 1; seOut = 32'd5;
        cyc("br_tk", 32'h0, 1'b0, 32'd12, 1'b1);
        // branch signals with invalid EX slot are ignored
        cyc("br_inv", 32'd8, 1'b1, 32'd28, 1'b0);
        clr();
        cyc("seq32", 32'd9, 1'b1, 32'd32, 1'b0);
        branch_ex = 1; zero_ex = 0; seOut = 32'd5;
        cyc("br_nt", 32'd10, 1'b1, 32'd36, 1'b0);
        clr();
        cyc("seq40", 32'd11, 1'b1, 32'd40, 1'b0);
        chk("addr40", {22'h0, imem_addr}, 32'd11);
        cyc("jfetch", 32'h0800_0040, 1'b1, 32'd44, 1'b0);
        cyc("jsquash", 32'h0, 1'b0, 32'd48, 1'b0);
        cyc("jtgt", 32'd65, 1'b1, 32'h100, 1'b0);
        cyc("j2fetch", 32'h0800_0300, 1'b1, 32'h104, 1'b0);
        // jr with stall and a jump in ID; branch also set, jr wins
        jr_ex = 1; reg_Da = 32'h0000_0203; stall = 1; branch_ex = 1; zero_ex = 1; seOut = 32'd5;
        cyc("jr", 32'h0, 1'b0, 32'h108, 1'b1);
        clr();
        cyc("jrtgt", 32'd129, 1'b1, 32'h200, 1'b0);
        cyc("j3fetch", 32'h0800_0010, 1'b1, 32'h204, 1'b0);
        stall = 1;
        cyc("jst", 32'h0, 1'b0, 32'h208, 1'b0);
        stall = 0;
        cyc("jst_rel", 32'h0, 1'b0, 32'h208, 1'b0);
        cyc("j3tgt", 32'd17, 1'b1, 32'h40, 1'b0);
        cyc("seq44", 32'd18, 1'b1, 32'h44, 1'b0);
        // reset coincides with a taken branch
        rst = 1; branch_ex = 1; zero_ex = 1; seOut = 32'd5;
        cyc("rst_br", 32'h0, 1'b0, 32'h48, 1'b0);
        rst = 0; clr();
        cyc("boot2", 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("r2f0", 32'd1, 1'b1, 32'h0, 1'b0);
        cyc("r2f4", 32'd2, 1'b1, 32'h4, 1'b0);
        // jr to top of address space, then sequential wrap
        jr_ex = 1; reg_Da = 32'hFFFF_FFFF;
        cyc("jr_top", 32'h0, 1'b0, 32'h8, 1'b1);
        clr();
        chk("addr_top", {22'h0, imem_addr}, 32'h3FF);
        cyc("top", 32'd1024, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc("wrap", 32'd1, 1'b1, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
